// File: rtl/decode_ctrl_pipe.sv
// LEGv8 decode stage: one instruction per cycle into a registered ID/EX op with
// load-use bubble insertion, branch flush and a saturating stall counter.
// Optional ADDI/SUBI decode is enabled by defining DECODE_IMM_ALU_EN.
module decode_ctrl_pipe #(
    parameter int INSTR_LEN  = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 64,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_LEN-1:0]  instruction,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  Reg2Loc,
    output logic                  Branch,
    output logic                  MemRead,
    output logic                  MemtoReg,
    output logic                  MemWrite,
    output logic                  ALUSrc,
    output logic                  RegWrite,
    output logic                  UncondBranch,
    output logic [1:0]            ALUOp,
    output logic [10:0]           opcode_q,
    output logic [REG_ADDR_W-1:0] rn,
    output logic [REG_ADDR_W-1:0] rm2,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [DATA_W-1:0]     imm,
    output logic                  illegal,
    output logic [CNT_W-1:0]      stall_cnt
);

`ifdef DECODE_IMM_ALU_EN
    localparam bit IMM_ALU_EN = 1'b1;
`else
    localparam bit IMM_ALU_EN = 1'b0;
`endif

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [REG_ADDR_W-1:0] XZR = REG_ADDR_W'(31);

    typedef struct packed {
        logic                  reg2loc;
        logic                  branch;
        logic                  memread;
        logic                  memtoreg;
        logic                  memwrite;
        logic                  alusrc;
        logic                  regwrite;
        logic                  uncond;
        logic [1:0]            aluop;
        logic [10:0]           opcode;
        logic [REG_ADDR_W-1:0] rn;
        logic [REG_ADDR_W-1:0] rm2;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     imm;
        logic                  illegal;
    } idex_t;

    logic [10:0]           opc;
    logic [REG_ADDR_W-1:0] f_rn, f_rm, f_rt;
    logic is_r, is_ldur, is_stur, is_cbz, is_b, is_ialu;
    logic use_rn, use_rm, use_rt;
    logic hazard;
    idex_t dec;

    idex_t           op_q, op_d;
    logic            vld_q, vld_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    assign opc  = instruction[31:21];
    assign f_rn = REG_ADDR_W'(instruction[9:5]);
    assign f_rm = REG_ADDR_W'(instruction[20:16]);
    assign f_rt = REG_ADDR_W'(instruction[4:0]);

    assign is_r    = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_ORR);
    assign is_ldur = (opc == OP_LDUR);
    assign is_stur = (opc == OP_STUR);
    assign is_cbz  = (opc[10:3] == OP_CBZ);
    assign is_b    = (opc[10:5] == OP_B);
    assign is_ialu = IMM_ALU_EN && ((opc[10:1] == OP_ADDI) || (opc[10:1] == OP_SUBI));

    // Combinational decode of the incoming instruction, plus which fields it reads.
    always_comb begin
        dec        = '0;
        use_rn     = 1'b0;
        use_rm     = 1'b0;
        use_rt     = 1'b0;
        dec.opcode = opc;
        dec.rn     = f_rn;
        dec.rd     = f_rt;
        if (is_r) begin
            dec.regwrite = 1'b1;
            dec.aluop    = 2'b10;
            use_rn       = 1'b1;
            use_rm       = 1'b1;
        end else if (is_ldur) begin
            dec.memread  = 1'b1;
            dec.memtoreg = 1'b1;
            dec.alusrc   = 1'b1;
            dec.regwrite = 1'b1;
            dec.imm      = {{(DATA_W-9){instruction[20]}}, instruction[20:12]};
            use_rn       = 1'b1;
        end else if (is_stur) begin
            dec.reg2loc  = 1'b1;
            dec.memwrite = 1'b1;
            dec.alusrc   = 1'b1;
            dec.imm      = {{(DATA_W-9){instruction[20]}}, instruction[20:12]};
            use_rn       = 1'b1;
            use_rt       = 1'b1;
        end else if (is_cbz) begin
            dec.reg2loc  = 1'b1;
            dec.branch   = 1'b1;
            dec.aluop    = 2'b01;
            dec.imm      = {{(DATA_W-19){instruction[23]}}, instruction[23:5]};
            use_rt       = 1'b1;
        end else if (is_b) begin
            dec.uncond   = 1'b1;
            dec.imm      = {{(DATA_W-26){instruction[25]}}, instruction[25:0]};
        end else if (is_ialu) begin
            dec.alusrc   = 1'b1;
            dec.regwrite = 1'b1;
            dec.aluop    = 2'b11;
            dec.imm      = DATA_W'(instruction[21:10]);
            use_rn       = 1'b1;
        end else begin
            dec.illegal  = 1'b1;
        end
        dec.rm2 = dec.reg2loc ? f_rt : f_rm;
    end

    // Load-use: held load writes a register the incoming op reads (XZR never hazards).
    assign hazard = vld_q && op_q.memread && (op_q.rd != XZR) && in_valid &&
                    ((use_rn && (f_rn == op_q.rd)) ||
                     (use_rm && (f_rm == op_q.rd)) ||
                     (use_rt && (f_rt == op_q.rd)));

    assign in_ready = (!vld_q || out_ready) && !hazard && !flush;

    always_comb begin
        vld_d   = vld_q;
        op_d    = op_q;
        stall_d = stall_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (hazard && out_ready) begin
            vld_d = 1'b0;
            if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
        end else if (in_valid && in_ready) begin
            vld_d = 1'b1;
            op_d  = dec;
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            op_q    <= '0;
            stall_q <= '0;
        end else begin
            vld_q   <= vld_d;
            op_q    <= op_d;
            stall_q <= stall_d;
        end
    end

    assign out_valid    = vld_q;
    assign Reg2Loc      = op_q.reg2loc;
    assign Branch       = op_q.branch;
    assign MemRead      = op_q.memread;
    assign MemtoReg     = op_q.memtoreg;
    assign MemWrite     = op_q.memwrite;
    assign ALUSrc       = op_q.alusrc;
    assign RegWrite     = op_q.regwrite;
    assign UncondBranch = op_q.uncond;
    assign ALUOp        = op_q.aluop;
    assign opcode_q     = op_q.opcode;
    assign rn           = op_q.rn;
    assign rm2          = op_q.rm2;
    assign rd           = op_q.rd;
    assign imm          = op_q.imm;
    assign illegal      = op_q.illegal;
    assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: directed plan steps then randomized traffic against
// a table-driven reference model of the decode stage.
module tb_decode_ctrl_pipe;

    logic        clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] instruction;
    logic        Reg2Loc, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, UncondBranch;
    logic [1:0]  ALUOp;
    logic [10:0] opcode_q;
    logic [4:0]  rn, rm2, rd;
    logic [63:0] imm;
    logic        illegal;
    logic [1:0]  stall_cnt;

    decode_ctrl_pipe #(.INSTR_LEN(32), .REG_ADDR_W(5), .DATA_W(64), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .Reg2Loc(Reg2Loc), .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .UncondBranch(UncondBranch),
        .ALUOp(ALUOp), .opcode_q(opcode_q), .rn(rn), .rm2(rm2), .rd(rd), .imm(imm),
        .illegal(illegal), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected op: ctl bits in table order Reg2Loc..UncondBranch; src is the set of read regs.
    typedef struct packed {
        logic [7:0]  ctl;
        logic [1:0]  aluop;
        logic [10:0] opcode;
        logic [4:0]  rn, rm2, rd;
        logic [63:0] imm;
        logic        illegal;
        logic [31:0] src;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic m_valid;
    exp_t m_op;
    int   m_stall;
    logic [100:0] obs;

    assign obs = {Reg2Loc, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, UncondBranch,
                  ALUOp, opcode_q, rn, rm2, rd, imm, illegal};

    function automatic exp_t ref_dec(input logic [31:0] ins);
        exp_t e;
        logic signed [63:0] s;
        e        = '0;
        e.opcode = ins[31:21];
        e.rn     = ins[9:5];
        e.rd     = ins[4:0];
        casez (ins[31:21])
            11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
                e.ctl = 8'b00000010; e.aluop = 2'd2;
                e.src[ins[9:5]] = 1'b1; e.src[ins[20:16]] = 1'b1;
            end
            11'b11111000010: begin
                e.ctl = 8'b00110110; s = $signed(ins[20:12]); e.imm = s;
                e.src[ins[9:5]] = 1'b1;
            end
            11'b11111000000: begin
                e.ctl = 8'b10001100; s = $signed(ins[20:12]); e.imm = s;
                e.src[ins[9:5]] = 1'b1; e.src[ins[4:0]] = 1'b1;
            end
            11'b10110100???: begin
                e.ctl = 8'b11000000; e.aluop = 2'd1; s = $signed(ins[23:5]); e.imm = s;
                e.src[ins[4:0]] = 1'b1;
            end
            11'b000101?????: begin
                e.ctl = 8'b00000001; s = $signed(ins[25:0]); e.imm = s;
            end
`ifdef DECODE_IMM_ALU_EN
            11'b1001000100?, 11'b1101000100?: begin
                e.ctl = 8'b00000110; e.aluop = 2'd3; e.imm = 64'(ins[21:10]);
                e.src[ins[9:5]] = 1'b1;
            end
`endif
            default: e.illegal = 1'b1;
        endcase
        e.rm2 = e.ctl[7] ? ins[4:0] : ins[20:16];
        return e;
    endfunction

    function automatic logic [4:0] rreg();
        int k = $urandom_range(0, 4);
        return (k == 4) ? 5'd31 : 5'(k);
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 7))
            0: begin
                logic [10:0] op;
                case ($urandom_range(0, 3))
                    0: op = 11'b10001011000;
                    1: op = 11'b11001011000;
                    2: op = 11'b10001010000;
                    default: op = 11'b10101010000;
                endcase
                return {op, rreg(), r[5:0], rreg(), rreg()};
            end
            1, 7: return {11'b11111000010, r[8:0], 2'b00, rreg(), rreg()};
            2: return {11'b11111000000, r[8:0], 2'b00, rreg(), rreg()};
            3: return {8'hB4, r[18:0], rreg()};
            4: return {6'b000101, r[25:0]};
            5: return {r[31] ? 10'b1001000100 : 10'b1101000100, r[11:0], rreg(), rreg()};
            default: return r;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // One cycle: drive, check in_ready, clock, advance model, check registered outputs.
    task automatic step(input logic iv, input logic [31:0] ins, input logic fl, input logic ordy);
        exp_t d;
        logic hz, rdy;
        in_valid = iv; instruction = ins; flush = fl; out_ready = ordy;
        d   = ref_dec(ins);
        hz  = m_valid && m_op.ctl[5] && (m_op.rd != 5'd31) && d.src[m_op.rd] && iv;
        rdy = (!m_valid || ordy) && !hz && !fl;
        #1;
        chk("in_ready", in_ready, rdy);
        @(posedge clk);
        if (fl) m_valid = 1'b0;
        else if (hz && ordy) begin
            m_valid = 1'b0;
            if (m_stall < 3) m_stall++;
        end else if (iv && rdy) begin
            m_valid = 1'b1;
            m_op    = d;
        end else if (ordy) m_valid = 1'b0;
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("stall_cnt", stall_cnt, m_stall);
        if (m_valid)
            chk("op_fields", obs,
                {m_op.ctl, m_op.aluop, m_op.opcode, m_op.rn, m_op.rm2, m_op.rd, m_op.imm, m_op.illegal});
    endtask

    initial begin
        m_valid = 1'b0; m_op = '0; m_stall = 0;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; instruction = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fields", obs, 0);
        chk("rst_stall", stall_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD X3,X1,X2
        step(1, 32'h8B020023, 0, 1);
        chk("add_valid", out_valid, 1);
        chk("add_regwrite", RegWrite, 1);
        chk("add_aluop", ALUOp, 2'b10);
        chk("add_regs", {rn, rm2, rd}, {5'd1, 5'd2, 5'd3});

        // LDUR X1 then dependent ADD X3,X1,X4
        step(1, 32'hF8400041, 0, 1);
        step(1, 32'h8B040023, 0, 1);
        chk("lu_bubble", out_valid, 0);
        chk("lu_stall", stall_cnt, 1);
        step(1, 32'h8B040023, 0, 1);
        chk("lu_add_valid", out_valid, 1);
        chk("lu_add_rm2", rm2, 4);

        // CBZ X5,#4 held under backpressure
        step(1, 32'hB4000085, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h8B020023, 0, 0);
            chk("cbz_hold", {Reg2Loc, Branch, rm2, imm}, {1'b1, 1'b1, 5'd5, 64'd4});
            chk("cbz_in_ready", in_ready, 0);
        end
        step(1, 32'h8B020023, 0, 1);

        // Flush while B #16 held and an op waits
        step(1, 32'h14000010, 0, 1);
        chk("b_imm", imm, 16);
        step(1, 32'h8B040023, 1, 0);
        chk("flush_drop", out_valid, 0);
        step(1, 32'h8B040023, 0, 1);
        chk("flush_retry_rm2", rm2, 4);

        // ADDI X1,X2,#5
        step(1, 32'h91001441, 0, 1);
`ifdef DECODE_IMM_ALU_EN
        chk("addi_alu", {ALUSrc, ALUOp, imm}, {1'b1, 2'b11, 64'd5});
`else
        chk("addi_illegal", {illegal, RegWrite}, {1'b1, 1'b0});
`endif

        // Repeated load-use hazards saturate the 2-bit counter
        for (int i = 0; i < 4; i++) begin
            step(1, 32'hF8400041, 0, 1);
            step(1, 32'h8B040023, 0, 1);
            step(1, 32'h8B040023, 0, 1);
        end
        chk("stall_sat", stall_cnt, 3);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, rand_ins(), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0);

        // Asynchronous reset mid-cycle empties the stage
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_fields", obs, 0);
        chk("arst_stall", stall_cnt, 0);
        m_valid = 1'b0; m_op = '0; m_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++)
            step(1, rand_ins(), 0, $urandom_range(0, 1) != 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
